// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one valid/ready input stream fanned out to
// CHANNELS valid/ready output streams, plus the dropped-transfer counter.
interface demux_stream_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]          in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [7:0]                drop_count;

  // Upstream producer and downstream consumers side
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, drop_count
  );

  // Demultiplexer side
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, drop_count
  );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-CHANNELS stream demultiplexer with a one-entry holding register per channel.
// Optional feature macro: DEMUX_STREAM_DROP_CNT_EN (8-bit saturating invalid-sel drop counter).
module demux_stream #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  demux_stream_if.slave   io_bus
);

  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0][WIDTH-1:0] r_data_q;
  logic [CHANNELS-1:0]            r_valid;

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_free;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_consume;
  logic                w_sel_ok;
  logic                w_ready;
  logic                w_accept;

  // Decode sel; an out-of-range sel hits no channel and is always accepted
  always_comb begin
    w_hit = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_hit[k] = (32'(io_bus.sel) == k);
    end
    w_free    = ~r_valid | io_bus.out_ready;
    w_sel_ok  = |w_hit;
    w_ready   = ~w_sel_ok | (|(w_hit & w_free));
    w_accept  = io_bus.in_valid & w_ready;
    w_wr      = w_accept ? w_hit : '0;
    w_consume = r_valid & io_bus.out_ready;
  end

  // Holding registers; a write wins over a same-edge consume to keep full throughput
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
      r_valid  <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (w_wr[k]) begin
          r_data_q[k] <= io_bus.in_data;
          r_valid[k]  <= 1'b1;
        end else if (w_consume[k]) begin
          r_valid[k]  <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_STREAM_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop = w_accept & ~w_sel_ok;

  // Saturating count of transfers discarded for an out-of-range sel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign io_bus.drop_count = r_drop_cnt;
`else
  assign io_bus.drop_count = 8'd0;
`endif

  assign io_bus.in_ready  = w_ready;
  assign io_bus.out_data  = r_data_q;
  assign io_bus.out_valid = r_valid;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a 4-channel instance for routing/back-pressure/streaming
// and a 3-channel instance for out-of-range sel, drop counting and asynchronous reset.
module tb_demux_stream;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

`ifdef DEMUX_STREAM_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  demux_stream_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
  demux_stream_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  demux_stream #(.WIDTH(8), .CHANNELS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io_bus(bus4));
  demux_stream #(.WIDTH(8), .CHANNELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .io_bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       vld;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    int         chk_ch;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [1:0] s, input logic [7:0] d, input logic v, input logic [3:0] r);
    bus4.sel       = s;
    bus4.in_data   = d;
    bus4.in_valid  = v;
    bus4.out_ready = r;
  endtask

  task automatic drive3(input logic [1:0] s, input logic [7:0] d, input logic v, input logic [2:0] r);
    bus3.sel       = s;
    bus3.in_data   = d;
    bus3.in_valid  = v;
    bus3.out_ready = r;
  endtask

  function automatic logic [7:0] ch4(input int k);
    logic [31:0] flat;
    flat = bus4.out_data;
    return flat[k*8 +: 8];
  endfunction

  function automatic logic [7:0] ch3(input int k);
    logic [23:0] flat;
    flat = bus3.out_data;
    return flat[k*8 +: 8];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_drop;

    // sel, data, vld, out_ready, exp in_ready, exp out_valid, checked channel, exp data
    vecs[0]  = '{2'd2, 8'hA5, 1'b1, 4'b0000, 1'b1, 4'b0100, 2, 8'hA5};
    vecs[1]  = '{2'd1, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b0110, 1, 8'h11};
    vecs[2]  = '{2'd1, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b0110, 1, 8'h11};
    vecs[3]  = '{2'd1, 8'h22, 1'b1, 4'b0010, 1'b1, 4'b0110, 1, 8'h22};
    vecs[4]  = '{2'd0, 8'h44, 1'b1, 4'b0000, 1'b1, 4'b0111, 0, 8'h44};
    vecs[5]  = '{2'd0, 8'h55, 1'b1, 4'b0000, 1'b0, 4'b0111, 0, 8'h44};
    vecs[6]  = '{2'd3, 8'h33, 1'b1, 4'b0000, 1'b1, 4'b1111, 3, 8'h33};
    vecs[7]  = '{2'd3, 8'h00, 1'b0, 4'b0000, 1'b0, 4'b1111, 0, 8'h44};
    vecs[8]  = '{2'd2, 8'h00, 1'b0, 4'b0100, 1'b1, 4'b1011, 2, 8'hA5};
    vecs[9]  = '{2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 3, 8'h33};
    vecs[10] = '{2'd0, 8'h00, 1'b0, 4'b0000, 1'b1, 4'b0000, 1, 8'h22};

    rst_n = 1'b0;
    drive4(2'd0, 8'h00, 1'b0, 4'b0000);
    drive3(2'd0, 8'h00, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_out_valid4", 32'(bus4.out_valid), 32'h0);
    chk("rst_out_data4", bus4.out_data, 32'h0);
    for (int s = 0; s < 4; s++) begin
      drive4(2'(s), 8'h00, 1'b0, 4'b0000);
      #1 chk($sformatf("rst_in_ready4_sel%0d", s), 32'(bus4.in_ready), 32'h1);
    end
    chk("rst_out_valid3", 32'(bus3.out_valid), 32'h0);
    chk("rst_drop3", 32'(bus3.drop_count), 32'h0);
    tick();

    // Route, back-pressure, same-edge consume+write, channel independence
    for (int i = 0; i < 11; i++) begin
      drive4(vecs[i].sel, vecs[i].data, vecs[i].vld, vecs[i].ordy);
      #2 chk($sformatf("vec%0d_in_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(bus4.out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_ch%0d_data", i, vecs[i].chk_ch), 32'(ch4(vecs[i].chk_ch)),
          32'(vecs[i].exp_d));
    end

    // Streaming to ch0 at one transfer per cycle with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      drive4(2'd0, 8'(i * 7 + 3), 1'b1, 4'b0001);
      #2 chk($sformatf("stream%0d_in_ready", i), 32'(bus4.in_ready), 32'h1);
      tick();
      chk($sformatf("stream%0d_valid", i), 32'(bus4.out_valid), 32'h1);
      chk($sformatf("stream%0d_data", i), 32'(ch4(0)), 32'(8'(i * 7 + 3)));
    end
    drive4(2'd0, 8'h00, 1'b0, 4'b0001);
    tick();
    chk("stream_drain_valid", 32'(bus4.out_valid), 32'h0);
    drive4(2'd0, 8'h00, 1'b0, 4'b0000);

    // 3-channel instance: park data in ch0, then an out-of-range sel
    drive3(2'd0, 8'h10, 1'b1, 3'b000);
    tick();
    chk("c3_ch0_fill_valid", 32'(bus3.out_valid), 32'h1);
    drive3(2'd3, 8'h7E, 1'b1, 3'b000);
    #2 chk("c3_bad_sel_in_ready", 32'(bus3.in_ready), 32'h1);
    tick();
    exp_drop = 1;
    chk("c3_bad_sel_valid", 32'(bus3.out_valid), 32'h1);
    chk("c3_bad_sel_ch0", 32'(ch3(0)), 32'h10);
    chk("c3_drop_first", 32'(bus3.drop_count), DROP_EN ? 32'(exp_drop) : 32'h0);

    // 300 further drops; the counter must saturate at 255
    for (int i = 0; i < 300; i++) begin
      tick();
      exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
      chk($sformatf("c3_drop_%0d", exp_drop), 32'(bus3.drop_count),
          DROP_EN ? 32'(exp_drop) : 32'h0);
    end
    chk("c3_drop_saturated_valid", 32'(bus3.out_valid), 32'h1);

    // Fill ch1 and ch2, then reset asynchronously between edges
    drive3(2'd1, 8'h21, 1'b1, 3'b000);
    tick();
    drive3(2'd2, 8'h32, 1'b1, 3'b000);
    tick();
    drive3(2'd0, 8'h00, 1'b0, 3'b000);
    chk("c3_full_valid", 32'(bus3.out_valid), 32'h7);
    chk("c3_full_ch2", 32'(ch3(2)), 32'h32);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid3", 32'(bus3.out_valid), 32'h0);
    chk("async_rst_data3", 32'(bus3.out_data), 32'h0);
    chk("async_rst_drop3", 32'(bus3.drop_count), 32'h0);
    drive3(2'd3, 8'h00, 1'b0, 3'b000);
    #1 chk("async_rst_in_ready_bad_sel", 32'(bus3.in_ready), 32'h1);
    drive3(2'd1, 8'h00, 1'b0, 3'b000);
    #1 chk("async_rst_in_ready_sel1", 32'(bus3.in_ready), 32'h1);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_valid3", 32'(bus3.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised registered 1-to-N stream demultiplexer. It routes a single valid/ready input stream to one of CHANNELS output streams, chosen per transfer by `sel`. Each output has a one-entry holding register, so a stalled channel back-pressures the input only when that channel is the one selected. It replaces the fixed 1-to-4 combinational enable demux in the board-level datapath, where multi-bit data must be steered to seven-segment, LED and UART consumers.

## Interface
- `WIDTH`, default 8: data width per channel in bits; range 1..32.
- `CHANNELS`, default 4: number of output channels; range 2..16.
- `SEL_W`: localparam, `$clog2(CHANNELS)`.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is taken synchronously to `clk` upstream.
- `in_data`  in  WIDTH: input payload.
- `in_valid`  in  1: input payload and `sel` are valid.
- `in_ready`  out  1: block accepts the input this cycle.
- `sel`  in  SEL_W: destination channel, sampled only on an accepted transfer.
- `out_data`  out  CHANNELS*WIDTH: channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `out_valid`  out  CHANNELS: per-channel valid.
- `out_ready`  in  CHANNELS: per-channel consumer ready.
- `drop_count`  out  8: saturating count of dropped transfers (see Configuration).

## Operation
- The input transfer (accept) occurs when `in_valid && in_ready` on a rising `clk` edge.
- Each channel k has a holding register `data_q[k]` plus `out_valid[k]`. `out_data` and `out_valid` are driven directly from these registers. No combinational path runs from input to output.
- Channel k is free when `!out_valid[k] || out_ready[k]`.
- `in_ready` is combinational and depends on `sel`:
  - `sel < CHANNELS`: `in_ready` equals "channel `sel` is free".
  - `sel >= CHANNELS` (possible only when CHANNELS is not a power of two): `in_ready = 1`.
- Accept with a valid `sel`:
  - `data_q[sel] <= in_data`.
  - `out_valid[sel] <= 1`.
- Accept with an invalid `sel`:
  - The payload is discarded and no channel changes.
  - `drop_count` increments, saturating at 255.
- Output consume on channel k occurs when `out_valid[k] && out_ready[k]`. The channel then clears `out_valid[k]` unless the same edge also writes channel k.
- Simultaneous consume and write on the same channel: `out_valid` stays 1 and `data_q` takes the new data. This sustains full throughput of 1 transfer/cycle on a single channel.
- Writes and consumes on different channels are independent. Any number of channels may be consumed in one cycle.
- `data_q[k]` holds its value while `out_valid[k] = 0`. It changes only on a write.
- Reset (asynchronous, any time, including mid-transfer):
  - `out_valid` = 0 and all `data_q` = 0.
  - `drop_count` = 0.
  - `in_ready` then equals 1 for any `sel`.
  - Data in flight is lost. No partial state survives.

## Timing
- Latency is 1 cycle: data accepted at edge n appears on `out_data`, with `out_valid` high, after edge n.
- Throughput is 1 transfer per cycle, including back-to-back transfers to the same channel while the consumer holds `out_ready = 1`.
- Stall: if channel `sel` is full and `out_ready[sel] = 0`, then `in_ready = 0`. Upstream must hold `in_data` and `sel` stable until acceptance.
- `out_valid[k]`, once asserted, stays high until consumed. Likewise `data_q[k]` stays stable while valid and unconsumed.
- Combinational paths: only `sel`/`out_valid`/`out_ready` → `in_ready`. No path from `in_valid` to `in_ready`.

## Configuration
- `DEMUX_STREAM_DROP_CNT_EN`:
  - Defined: the 8-bit saturating drop counter is compiled in and drives `drop_count`.
  - Undefined: the counter logic is omitted and `drop_count` is tied to 0. Invalid-`sel` transfers are still accepted and discarded.
  - Routing, handshake and timing are identical in both builds.

## Test plan
- Reset and basic route, WIDTH=8, CHANNELS=4: assert `rst_n` low, then release. Check all `out_valid` = 0, `out_data` = 0 and `in_ready` = 1. Send 0xA5 with `sel=2`. Next cycle expect `out_valid = 4'b0100` and channel 2 data = 0xA5.
- Back-pressure: with `out_ready = 0`, send 0x11 to ch1 and then 0x22 to ch1. Expect `in_ready = 0` after the first transfer and 0x11 held. Raise `out_ready[1]` and expect 0x11 consumed and 0x22 loaded on the same edge, with `out_valid[1]` staying 1.
- Independence: ch0 full and stalled, then send 0x33 to ch3. Expect immediate accept and ch3 = 0x33, with ch0 unchanged.
- Streaming: 16 consecutive transfers to ch0 with `out_ready[0] = 1`. Expect `in_ready` high throughout and consumer sequence = input sequence, with 1-cycle latency.
- Invalid sel, CHANNELS=3: send 0x7E with `sel=3`. Expect accept and no `out_valid` change. With the macro defined, expect `drop_count` = 1; after 300 drops, expect 255. With the macro undefined, expect `drop_count` = 0.
- Reset mid-operation: fill ch0–ch2 and pulse `rst_n` low between clock edges. Expect `out_valid = 0` immediately, without waiting for a clock edge, and `drop_count` = 0.
